// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode handshake bundle for the instruction fetch queue
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             fetch_valid_f;
    logic [31:0]      PC_f;
    logic [31:0]      Instruction_f;
    logic             fetch_ready_f;
    logic             flush;
    logic             decode_ready_d;
    logic             decode_valid_d;
    logic [31:0]      PC_d;
    logic [31:0]      Instruction_d;
    logic [31:0]      PC_plus4_d;
    logic             misaligned_d;
    logic [CNT_W-1:0] count;

    // the queue itself
    modport master (
        input  fetch_valid_f, PC_f, Instruction_f, flush, decode_ready_d,
        output fetch_ready_f, decode_valid_d, PC_d, Instruction_d, PC_plus4_d,
               misaligned_d, count
    );

    // the surrounding fetch/decode stages
    modport slave (
        output fetch_valid_f, PC_f, Instruction_f, flush, decode_ready_d,
        input  fetch_ready_f, decode_valid_d, PC_d, Instruction_d, PC_plus4_d,
               misaligned_d, count
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular (PC, instruction) FIFO between fetch and decode; optional FETCH_QUEUE_BYPASS_EN
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP_INSN = 32'h0000_0013;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] pc_mem_q  [DEPTH];
    logic [31:0] ins_mem_q [DEPTH];
    logic        mis_mem_q [DEPTH];

    logic        push;
    logic        pop;
    logic        byp_take;
    logic        head_valid;
    logic [31:0] head_pc;
    logic [31:0] head_ins;
    logic        head_mis;

    // ready depends on registered occupancy only, never on decode_ready_d
    assign bus.fetch_ready_f = rst_n & (count_q != FULL_CNT);
    assign bus.count         = count_q;

    // head selection: stored head, or the incoming fetch when bypassing an empty queue
    always_comb begin
        byp_take   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_take   = rst_n & (count_q == '0) & bus.fetch_valid_f & ~bus.flush;
`endif
        head_valid = 1'b0;
        head_pc    = 32'h0;
        head_ins   = NOP_INSN;
        head_mis   = 1'b0;
        if (byp_take) begin
            head_valid = 1'b1;
            head_pc    = bus.PC_f;
            head_ins   = bus.Instruction_f;
            head_mis   = (bus.PC_f[1:0] != 2'b00);
        end else if (count_q != '0) begin
            head_valid = 1'b1;
            head_pc    = pc_mem_q[rd_ptr_q];
            head_ins   = ins_mem_q[rd_ptr_q];
            head_mis   = mis_mem_q[rd_ptr_q];
        end
    end

    assign bus.decode_valid_d = head_valid;
    assign bus.PC_d           = head_pc;
    assign bus.Instruction_d  = head_ins;
    assign bus.misaligned_d   = head_mis;
    assign bus.PC_plus4_d     = head_pc + 32'd4;

    // pointer/occupancy next state; flush beats push and pop
    always_comb begin
        push     = bus.fetch_valid_f & bus.fetch_ready_f & ~bus.flush
                   & ~(byp_take & bus.decode_ready_d);
        pop      = head_valid & bus.decode_ready_d & ~bus.flush & ~byp_take;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // control state register; reset empties the queue without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // entry storage is not reset; only slots below count are ever observed
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= bus.PC_f;
            ins_mem_q[wr_ptr_q] <= bus.Instruction_f;
            mis_mem_q[wr_ptr_q] <= (bus.PC_f[1:0] != 2'b00);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue
module tb_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    ent_t model[$];

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                          input logic fl, input logic dr);
        bus.fetch_valid_f  = fv;
        bus.PC_f           = pc;
        bus.Instruction_f  = ins;
        bus.flush          = fl;
        bus.decode_ready_d = dr;
    endtask

    // monitor: compare DUT against the queue model, then apply the coming edge to the model
    always @(negedge clk) begin
        ent_t h;
        bit   ev;
        bit   byp;
        bit   psh;
        bit   pp;
        if (!rst_n) begin
            chk("rst_valid", 32'(bus.decode_valid_d), 32'd0);
            chk("rst_ready", 32'(bus.fetch_ready_f), 32'd0);
            chk("rst_count", 32'(bus.count), 32'd0);
            model.delete();
        end else begin
            byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (model.size() == 0) && bus.fetch_valid_f && !bus.flush;
`endif
            ev = (model.size() != 0) || byp;
            if (byp)     h = {bus.PC_f, bus.Instruction_f};
            else if (ev) h = model[0];
            else         h = {32'h0, 32'h0000_0013};
            chk("count", 32'(bus.count), 32'(model.size()));
            chk("fetch_ready", 32'(bus.fetch_ready_f), 32'(model.size() != DEPTH));
            chk("decode_valid", 32'(bus.decode_valid_d), 32'(ev));
            chk("PC_d", bus.PC_d, h.pc);
            chk("Instruction_d", bus.Instruction_d, h.ins);
            chk("PC_plus4_d", bus.PC_plus4_d, h.pc + 32'd4);
            chk("misaligned_d", 32'(bus.misaligned_d), 32'(h.pc[1:0] != 2'b00));
            if (bus.flush) begin
                model.delete();
            end else begin
                psh = bus.fetch_valid_f && (model.size() < DEPTH);
                pp  = ev && bus.decode_ready_d;
                if (byp) begin
                    if (!pp) model.push_back(h);
                end else begin
                    if (pp)  void'(model.pop_front());
                    if (psh) model.push_back({bus.PC_f, bus.Instruction_f});
                end
            end
        end
    end

    task automatic random_phase(input int cycles);
        logic        fv = 1'b0;
        logic [31:0] pc = 32'h0;
        logic [31:0] ins = 32'h0;
        bit          acc = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (acc) begin
                fv  = ($urandom_range(0, 3) != 0);
                pc  = $urandom;
                if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
                ins = $urandom;
            end
            set_in(fv, pc, ins, ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0));
            acc = !fv || bus.fetch_ready_f || bus.flush;
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("rst_insn", bus.Instruction_d, 32'h0000_0013);
        chk("rst_pc", bus.PC_d, 32'h0);
        tick();
        rst_n = 1'b1;

        // first push, decode stalled
        set_in(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("first_valid", 32'(bus.decode_valid_d), 32'd1);
        chk("first_pc", bus.PC_d, 32'h0);
        chk("first_plus4", bus.PC_plus4_d, 32'h4);
        chk("first_count", 32'(bus.count), 32'd1);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();

        // fill to full, fifth fetch ignored, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h10, 32'h2000, 1'b0, 1'b0);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ready", 32'(bus.fetch_ready_f), 32'd0);
        tick();
        chk("full_head", bus.PC_d, 32'h0);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", bus.PC_d, 32'(i * 4));
            tick();
        end
        chk("drained", 32'(bus.count), 32'd0);

        // sustained push+pop across pointer wrap
        set_in(1'b1, 32'h100, 32'h3000, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            set_in(1'b1, 32'h100 + 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b1);
            tick();
            chk("stream_count", 32'(bus.count), 32'd1);
            chk("stream_pc", bus.PC_d, 32'h100 + 32'(i * 4));
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();

        // flush with three queued and an incoming fetch
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h200 + 32'(i * 4), 32'h4000, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h40, 32'h5000, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_valid", 32'(bus.decode_valid_d), 32'd0);
        chk("flush_insn", bus.Instruction_d, 32'h0000_0013);
        tick();

        // PC wraparound and misaligned entries
        set_in(1'b1, 32'hFFFF_FFFC, 32'h6000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("wrap_plus4", bus.PC_plus4_d, 32'h0);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 32'h2, 32'h7000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("misaligned", 32'(bus.misaligned_d), 32'd1);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();

        random_phase(3000);

        // asynchronous reset with two queued entries
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h300 + 32'(i * 4), 32'h8000, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.decode_valid_d), 32'd0);
        chk("async_ready", 32'(bus.fetch_ready_f), 32'd0);
        chk("async_count", 32'(bus.count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        random_phase(300);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the PC/instruction-memory fetch stage and the decode stage of the RISC-V pipeline. It buffers (PC, instruction) pairs produced by fetch in a small circular FIFO, so fetch keeps running while decode stalls. It presents the oldest pair to decode with a valid/ready handshake. A branch redirect flushes all buffered wrong-path instructions in one cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_valid_f  in  1  PC_f/Instruction_f carry a fetched instruction this cycle
- PC_f  in  32  address of fetched instruction
- Instruction_f  in  32  fetched instruction word
- fetch_ready_f  out  1  queue accepts a push this cycle
- flush  in  1  branch redirect; discard all queued and incoming entries
- decode_ready_d  in  1  decode consumes head entry this cycle
- decode_valid_d  out  1  head entry valid
- PC_d  out  32  PC of head entry
- Instruction_d  out  32  instruction of head entry
- PC_plus4_d  out  32  PC_d + 4, modulo 2^32
- misaligned_d  out  1  head entry's PC[1:0] != 2'b00
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry array of {PC[31:0], Instruction[31:0], misaligned}. Pointers wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. count is held in a separate register.
- push = fetch_valid_f & fetch_ready_f & ~flush. On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = decode_valid_d & decode_ready_d & ~flush. On pop, rd_ptr increments.
- Count update: push only → +1; pop only → −1; both → unchanged.
- fetch_ready_f = rst_n & (count != DEPTH). It depends on registered state only; there is no combinational path from decode_ready_d.
- Full: fetch_ready_f = 0. Fetch must hold PC_f/Instruction_f stable until accepted.
- Empty: decode_valid_d = 0, PC_d = 0, Instruction_d = 32'h0000_0013 (NOP), misaligned_d = 0. PC_plus4_d = 4.
- flush has priority over push and pop. On the next edge, wr_ptr = rd_ptr = 0 and count = 0. The Instruction_f presented in the flush cycle is dropped.
- misaligned_d is informational only. Misaligned entries are queued and popped like any other entry.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs during reset: decode_valid_d = 0, fetch_ready_f = 0, PC_d = 0, Instruction_d = 32'h0000_0013, misaligned_d = 0.
  - Storage array contents are not reset.
- After the rst_n rising edge, the first clk edge may accept a push.
- Reset asserted mid-operation: the queue empties immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N appears at the head (decode_valid_d = 1) after edge N, when the queue was empty. Latency is 1 cycle without the bypass option.
- Throughput: one push and one pop per cycle, sustained at any occupancy from 1 to DEPTH−1.
- Full with decode_ready_d = 1: the pop frees one slot. fetch_ready_f rises only on the following cycle.
- Head outputs are read combinationally from the array at rd_ptr and masked by decode_valid_d.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - Bypass case: when count == 0, fetch_valid_f = 1 and flush = 0, the block drives decode_valid_d = 1 and routes PC_f/Instruction_f combinationally to PC_d/Instruction_d/misaligned_d.
  - If decode_ready_d = 1 in that cycle, the entry is consumed and not written, so count stays 0.
  - Otherwise the entry is pushed normally.
  - Result: zero-cycle latency when the queue is empty.
- FETCH_QUEUE_BYPASS_EN undefined: every entry passes through storage, giving 1-cycle minimum latency. There is no combinational path from the fetch side to the decode side.

## Test plan
- Reset, then push PC 0x0 / Instruction 0x00500093 with decode_ready_d = 0:
  - Without bypass: next cycle decode_valid_d = 1, PC_d = 0x0, PC_plus4_d = 0x4, count = 1.
- Push 4 entries (PCs 0x0, 0x4, 0x8, 0xC) with decode_ready_d = 0 → count = 4 and fetch_ready_f = 0. A fifth fetch_valid_f is ignored. Then drain → PCs appear in order 0x0, 0x4, 0x8, 0xC.
- Continuous push/pop for 10 cycles with PCs 0x100 upward → count stays constant and pointers wrap past DEPTH−1 with no lost or duplicated PC.
- With count = 3, assert flush together with fetch_valid_f (PC 0x40) → next cycle count = 0, decode_valid_d = 0, Instruction_d = 0x00000013. PC 0x40 is never presented.
- Push PC 0xFFFFFFFC → PC_plus4_d = 0x0. Push PC 0x2 → misaligned_d = 1.
- Deassert rst_n asynchronously with count = 2 → decode_valid_d = 0 and fetch_ready_f = 0 immediately, before any clk edge.
